// File: rtl/con_replay_pkg.sv
// Shared definitions for the controller-frame replay block.
// Holds the parameter defaults and the shift-state enumeration used by
// con_serial_replay and con_edge_filter.
package con_replay_pkg;

  localparam int NUM_BITS_DEF    = 16;  // SNES pad; NES uses 8
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 8;   // ~48 ns at 168 MHz
  localparam int CNT_W_DEF       = 16;

  typedef enum logic [1:0] {
    ST_IDLE,     // frame fully shifted (or none yet), data line released high
    ST_LATCHED,  // console latch high, bit0 presented
    ST_SHIFT     // latch low, advancing one bit per console clock rise
  } state_e;

endpackage

// File: rtl/con_edge_filter.sv
// Conditions one asynchronous console line.
// A SYNC_STAGES-deep synchroniser feeds a stability counter: the filtered
// level only takes the synchronised value after FILT_CYCLES consecutive
// samples that differ from the current filtered level. Rise/fall pulses are
// registered alongside the filtered level, so they appear on the same edge
// the level changes.
// Ports:
//   clk_i   system clock
//   srst_i  synchronous active-high reset
//   pin_i   raw asynchronous pin
//   level_o filtered level (RESET_VAL after reset)
//   rise_o  1-cycle pulse on filtered 0->1
//   fall_o  1-cycle pulse on filtered 1->0
module con_edge_filter
  import con_replay_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   FILT_CYCLES = FILT_CYCLES_DEF,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic pin_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, fall_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // cnt_q counts how many samples in a row have disagreed with level_q;
  // any agreeing sample restarts the count, which is what rejects glitches.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = synced;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q  <= {SYNC_STAGES{RESET_VAL}};
      cnt_q   <= '0;
      level_q <= RESET_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pin_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/con_serial_replay.sv
// Replays recorded controller frames onto a SNES-style latch/clock/data pad.
// Each filtered latch rise pulls one word from the upstream frame buffer
// (or repeats the previous word and flags UNDERRUN when none is valid);
// each filtered console clock rise afterwards shifts out the next bit.
// Ports:
//   CLK          168 MHz system clock
//   RESET        synchronous active-high reset
//   CON_LATCH    console latch pin (async)
//   CON_CLK      console clock pin (async, idle high)
//   CON_DATA     pad data, active-low
//   FRAME_DATA   next frame word, bit0 first, 1 = pressed
//   FRAME_VALID  FRAME_DATA valid
//   FRAME_READY  1-cycle transfer pulse
//   UNDERRUN     1-cycle pulse when a latch found no valid word
//   LATCH_COUNT  filtered latch rises, wrapping
module con_serial_replay
  import con_replay_pkg::*;
#(
  parameter int NUM_BITS    = NUM_BITS_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                CON_LATCH,
  input  logic                CON_CLK,
  output logic                CON_DATA,
  input  logic [NUM_BITS-1:0] FRAME_DATA,
  input  logic                FRAME_VALID,
  output logic                FRAME_READY,
  output logic                UNDERRUN,
  output logic [CNT_W-1:0]    LATCH_COUNT
);

  localparam int BIDX_W = $clog2(NUM_BITS + 1);
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(NUM_BITS - 1);
  localparam logic [BIDX_W-1:0] IDLE_IDX = BIDX_W'(NUM_BITS);

  logic latch_lvl, latch_rise, latch_fall;
  logic clk_rise, clk_lvl_unused, clk_fall_unused;

  con_edge_filter #(
    .SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES), .RESET_VAL(1'b0)
  ) u_latch_filt (
    .clk_i(CLK), .srst_i(RESET), .pin_i(CON_LATCH),
    .level_o(latch_lvl), .rise_o(latch_rise), .fall_o(latch_fall)
  );

  con_edge_filter #(
    .SYNC_STAGES(SYNC_STAGES), .FILT_CYCLES(FILT_CYCLES), .RESET_VAL(1'b1)
  ) u_clk_filt (
    .clk_i(CLK), .srst_i(RESET), .pin_i(CON_CLK),
    .level_o(clk_lvl_unused), .rise_o(clk_rise), .fall_o(clk_fall_unused)
  );

  state_e                state_q, state_d;
  logic [NUM_BITS-1:0]   shreg_q, shreg_d;
  logic [BIDX_W-1:0]     bit_idx_q, bit_idx_d, next_idx;
  logic                  data_q, data_d;
  logic                  underrun_q, underrun_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_BITS-1:0]   load_word;
  logic                  next_bit;

  // Bit that the next clock rise will present.
  always_comb begin
    next_idx = bit_idx_q + BIDX_W'(1);
    next_bit = 1'b0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (next_idx == BIDX_W'(i)) next_bit = shreg_q[i];
    end
  end

  // On underrun the previous frame is replayed rather than sending zeros.
  assign load_word = FRAME_VALID ? FRAME_DATA : shreg_q;

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    underrun_d = 1'b0;
    cnt_d      = cnt_q;
    if (latch_rise) begin
      // Latch wins over a coincident clock rise and aborts any shift.
      state_d    = ST_LATCHED;
      shreg_d    = load_word;
      bit_idx_d  = '0;
      data_d     = ~load_word[0];
      underrun_d = ~FRAME_VALID;
      cnt_d      = cnt_q + CNT_W'(1);
    end else begin
      if (state_q == ST_LATCHED && latch_fall) state_d = ST_SHIFT;
      // Level check (not state) so a clock rise in the cycle right after
      // the latch falls is still honoured.
      if (clk_rise && !latch_lvl && state_q != ST_IDLE) begin
        if (bit_idx_q == LAST_IDX) begin
          bit_idx_d = IDLE_IDX;
          data_d    = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          bit_idx_d = next_idx;
          data_d    = ~next_bit;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_idx_q  <= IDLE_IDX;
      data_q     <= 1'b1;
      underrun_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      underrun_q <= underrun_d;
      cnt_q      <= cnt_d;
    end
  end

  assign CON_DATA    = data_q;
  assign FRAME_READY = latch_rise;
  assign UNDERRUN    = underrun_q;
  assign LATCH_COUNT = cnt_q;

endmodule
